// File: rtl/pc_jump_ctrl.sv
// Control-flow writer for the PC overwrite port: JMP/CALL/RET with a return-address LIFO.
// Optional macro PC_JUMP_ERR_STICKY_EN makes the error flags latch until i_err_clr.
module pc_jump_ctrl #(
    parameter int SIZE  = 5,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_jmp,
    input  logic             i_call,
    input  logic             i_ret,
    input  logic [SIZE-1:0]  i_target,
    input  logic [SIZE-1:0]  i_pc_val,
    input  logic             i_err_clr,
    output logic             o_pc_overwrite,
    output logic [SIZE-1:0]  o_pc_new_val,
    output logic             o_pc_inc_hold,
    output logic [PTR_W-1:0] o_stack_depth,
    output logic             o_stack_full,
    output logic             o_stack_empty,
    output logic             o_err_ovf,
    output logic             o_err_unf,
    output logic             o_err_target
);

    localparam logic [SIZE-1:0]  MAX_VAL  = '1;
    localparam logic [SIZE-1:0]  PC_ONE   = SIZE'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

    logic [SIZE-1:0]  r_stack [DEPTH];
    logic [PTR_W-1:0] r_depth;
    logic             r_overwrite;
    logic [SIZE-1:0]  r_new_val;
    logic             r_err_ovf;
    logic             r_err_unf;
    logic             r_err_target;

    logic             w_do_call;
    logic             w_do_ret;
    logic             w_do_jmp;
    logic             w_full;
    logic             w_empty;
    logic [SIZE-1:0]  w_pop_val;
    logic [SIZE-1:0]  w_push_val;
    logic             w_push;
    logic             w_pop;
    logic             w_ovr;
    logic [SIZE-1:0]  w_ovr_val;
    logic             w_ev_ovf;
    logic             w_ev_unf;
    logic             w_ev_target;

    // Priority call > ret > jmp; losers are simply ignored.
    assign w_do_call  = i_call;
    assign w_do_ret   = i_ret & ~i_call;
    assign w_do_jmp   = i_jmp & ~i_call & ~i_ret;

    assign w_full     = (r_depth == PTR_FULL);
    assign w_empty    = (r_depth == '0);
    assign w_push_val = i_pc_val + PC_ONE;

    always_comb begin
        w_pop_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_depth == PTR_W'(i + 1)) begin
                w_pop_val = r_stack[i];
            end
        end
    end

    always_comb begin
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_ovr       = 1'b0;
        w_ovr_val   = '0;
        w_ev_ovf    = 1'b0;
        w_ev_unf    = 1'b0;
        w_ev_target = 1'b0;
        if (w_do_call) begin
            if (w_full) begin
                w_ev_ovf = 1'b1;
            end else if (i_target == MAX_VAL) begin
                w_ev_target = 1'b1;
            end else begin
                w_push    = 1'b1;
                w_ovr     = 1'b1;
                w_ovr_val = i_target;
            end
        end else if (w_do_ret) begin
            if (w_empty) begin
                w_ev_unf = 1'b1;
            end else begin
                // The entry is consumed even when its address is unusable.
                w_pop = 1'b1;
                if (w_pop_val == MAX_VAL) begin
                    w_ev_target = 1'b1;
                end else begin
                    w_ovr     = 1'b1;
                    w_ovr_val = w_pop_val;
                end
            end
        end else if (w_do_jmp) begin
            if (i_target == MAX_VAL) begin
                w_ev_target = 1'b1;
            end else begin
                w_ovr     = 1'b1;
                w_ovr_val = i_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_depth == PTR_W'(i))) begin
                r_stack[i] <= w_push_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_depth     <= '0;
            r_overwrite <= 1'b0;
            r_new_val   <= '0;
        end else begin
            if (w_push && !w_full) begin
                r_depth <= r_depth + PTR_ONE;
            end else if (w_pop && !w_empty) begin
                r_depth <= r_depth - PTR_ONE;
            end
            r_overwrite <= w_ovr;
            r_new_val   <= w_ovr_val;
        end
    end

`ifdef PC_JUMP_ERR_STICKY_EN
    // A fresh error in the clearing cycle takes precedence over the clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_ovf    <= 1'b0;
            r_err_unf    <= 1'b0;
            r_err_target <= 1'b0;
        end else begin
            r_err_ovf    <= w_ev_ovf    | (r_err_ovf    & ~i_err_clr);
            r_err_unf    <= w_ev_unf    | (r_err_unf    & ~i_err_clr);
            r_err_target <= w_ev_target | (r_err_target & ~i_err_clr);
        end
    end
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = i_err_clr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_ovf    <= 1'b0;
            r_err_unf    <= 1'b0;
            r_err_target <= 1'b0;
        end else begin
            r_err_ovf    <= w_ev_ovf;
            r_err_unf    <= w_ev_unf;
            r_err_target <= w_ev_target;
        end
    end
`endif

    assign o_pc_overwrite = r_overwrite;
    assign o_pc_new_val   = r_new_val;
    assign o_pc_inc_hold  = r_overwrite;
    assign o_stack_depth  = r_depth;
    assign o_stack_full   = w_full;
    assign o_stack_empty  = w_empty;
    assign o_err_ovf      = r_err_ovf;
    assign o_err_unf      = r_err_unf;
    assign o_err_target   = r_err_target;

endmodule

// File: tb/tb_pc_jump_ctrl.sv
// Scoreboard bench for pc_jump_ctrl: a reference model pushes expected results per
// command, and they are popped and compared one cycle later when the DUT responds.
module tb_pc_jump_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       i_jmp = 1'b0, i_call = 1'b0, i_ret = 1'b0, i_err_clr = 1'b0;
    logic [4:0] i_target = '0, i_pc_val = '0;
    logic       o_pc_overwrite, o_pc_inc_hold, o_stack_full, o_stack_empty;
    logic [4:0] o_pc_new_val;
    logic [2:0] o_stack_depth;
    logic       o_err_ovf, o_err_unf, o_err_target;

    pc_jump_ctrl #(.SIZE(5), .DEPTH(4)) dut (
        .clk(clk), .rstn(rstn),
        .i_jmp(i_jmp), .i_call(i_call), .i_ret(i_ret),
        .i_target(i_target), .i_pc_val(i_pc_val), .i_err_clr(i_err_clr),
        .o_pc_overwrite(o_pc_overwrite), .o_pc_new_val(o_pc_new_val),
        .o_pc_inc_hold(o_pc_inc_hold), .o_stack_depth(o_stack_depth),
        .o_stack_full(o_stack_full), .o_stack_empty(o_stack_empty),
        .o_err_ovf(o_err_ovf), .o_err_unf(o_err_unf), .o_err_target(o_err_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ovr;
        logic [4:0] nv;
        logic       eo;
        logic       eu;
        logic       et;
        logic [2:0] depth;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] m_stk[$];
    logic       m_eo = 1'b0, m_eu = 1'b0, m_et = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_out(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({name, "_ovr"},   32'(o_pc_overwrite), 32'(e.ovr));
        check({name, "_hold"},  32'(o_pc_inc_hold),  32'(e.ovr));
        if (e.ovr) check({name, "_newval"}, 32'(o_pc_new_val), 32'(e.nv));
        check({name, "_eovf"},  32'(o_err_ovf),      32'(e.eo));
        check({name, "_eunf"},  32'(o_err_unf),      32'(e.eu));
        check({name, "_etgt"},  32'(o_err_target),   32'(e.et));
        check({name, "_depth"}, 32'(o_stack_depth),  32'(e.depth));
        check({name, "_full"},  32'(o_stack_full),   32'(e.depth == 3'd4));
        check({name, "_empty"}, 32'(o_stack_empty),  32'(e.depth == 3'd0));
        $display("%s: ovr=%0d nv=%0d depth=%0d err=%0d%0d%0d",
                 name, o_pc_overwrite, o_pc_new_val, o_stack_depth,
                 o_err_ovf, o_err_unf, o_err_target);
    endtask

    // Drive one cycle of commands, predict, then compare after the edge.
    task automatic step(input string name, input logic c, input logic r, input logic j,
                        input logic [4:0] tgt, input logic [4:0] pcv, input logic clr);
        exp_t       e;
        logic       ev_o, ev_u, ev_t;
        logic [4:0] pv;
        e = '0; ev_o = 0; ev_u = 0; ev_t = 0;
        i_call = c; i_ret = r; i_jmp = j; i_target = tgt; i_pc_val = pcv; i_err_clr = clr;
        if (c) begin
            if (m_stk.size() == 4) ev_o = 1;
            else if (tgt == 5'd31) ev_t = 1;
            else begin
                pv = pcv + 5'd1;
                m_stk.push_back(pv);
                e.ovr = 1; e.nv = tgt;
            end
        end else if (r) begin
            if (m_stk.size() == 0) ev_u = 1;
            else begin
                pv = m_stk.pop_back();
                if (pv == 5'd31) ev_t = 1;
                else begin e.ovr = 1; e.nv = pv; end
            end
        end else if (j) begin
            if (tgt == 5'd31) ev_t = 1;
            else begin e.ovr = 1; e.nv = tgt; end
        end
`ifdef PC_JUMP_ERR_STICKY_EN
        m_eo = ev_o | (m_eo & ~clr);
        m_eu = ev_u | (m_eu & ~clr);
        m_et = ev_t | (m_et & ~clr);
`else
        m_eo = ev_o; m_eu = ev_u; m_et = ev_t;
`endif
        e.eo = m_eo; e.eu = m_eu; e.et = m_et;
        e.depth = 3'(m_stk.size());
        sb.push_back(e);
        @(posedge clk);
        #1;
        i_call = 0; i_ret = 0; i_jmp = 0; i_err_clr = 0;
        compare_out(name);
    endtask

    task automatic idle(input string name);
        step(name, 0, 0, 0, 5'd0, 5'd0, 0);
    endtask

    initial begin
        #12;
        check("rst_ovr",   32'(o_pc_overwrite), 32'd0);
        check("rst_depth", 32'(o_stack_depth),  32'd0);
        check("rst_empty", 32'(o_stack_empty),  32'd1);
        check("rst_errs",  32'({o_err_ovf, o_err_unf, o_err_target}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // jump, then pulse must end
        step("jmp9", 0, 0, 1, 5'd9, 5'd0, 0);
        idle("jmp9_end");

        // call/ret pair
        step("call20", 1, 0, 0, 5'd20, 5'd3, 0);
        step("ret4",   0, 1, 0, 5'd0,  5'd0, 0);
        idle("cr_end");

        // overflow then underflow
        for (int k = 0; k < 5; k++)
            step("call_fill", 1, 0, 0, 5'(k + 1), 5'(k + 10), 0);
        idle("ovf_end");
        for (int k = 0; k < 4; k++) step("ret_drain", 0, 1, 0, 5'd0, 5'd0, 0);
        step("ret_unf", 0, 1, 0, 5'd0, 5'd0, 0);
        idle("unf_end");

        // MAX_VAL targets and wrap of pc_val+1
        step("jmp31",     0, 0, 1, 5'd31, 5'd0, 0);
        step("call31",    1, 0, 0, 5'd31, 5'd2, 0);
        step("call_pc30", 1, 0, 0, 5'd7,  5'd30, 0);
        step("ret31",     0, 1, 0, 5'd0,  5'd0, 0);
        step("call_pc31", 1, 0, 0, 5'd6,  5'd31, 0);
        step("ret_wrap0", 0, 1, 0, 5'd0,  5'd0, 0);
        idle("max_end");

        // all commands at once: call wins
        step("all3",   1, 1, 1, 5'd12, 5'd2, 0);
        step("all3_r", 0, 1, 1, 5'd8,  5'd0, 0);

        // error persistence and clear (sticky build keeps it, pulse build drops it)
        for (int k = 0; k < 5; k++) step("stk_fill", 1, 0, 0, 5'd3, 5'(k), 0);
        for (int k = 0; k < 10; k++) idle("stk_hold");
        step("stk_clr_new", 1, 0, 0, 5'd3, 5'd0, 1);
        step("stk_clr", 0, 0, 0, 5'd0, 5'd0, 1);
        idle("stk_after");

        // random back-to-back traffic
        for (int k = 0; k < 60; k++)
            step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30)),
                 5'($urandom), 1'($urandom_range(0, 3) == 0));

        // reset asserted while a pulse is active
        while (m_stk.size() > 0) step("pre_rst_drain", 0, 1, 0, 5'd0, 5'd0, 0);
        step("call_pre_rst", 1, 0, 0, 5'd9, 5'd5, 0);
        rstn = 1'b0;
        #1;
        check("midrst_ovr",   32'(o_pc_overwrite), 32'd0);
        check("midrst_hold",  32'(o_pc_inc_hold),  32'd0);
        check("midrst_depth", 32'(o_stack_depth),  32'd0);
        check("midrst_empty", 32'(o_stack_empty),  32'd1);
        m_stk.delete(); m_eo = 0; m_eu = 0; m_et = 0;
        @(negedge clk);
        rstn = 1'b1;
        step("post_rst_ret", 0, 1, 0, 5'd0, 5'd0, 0);
        step("post_rst_jmp", 0, 0, 1, 5'd17, 5'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
